// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sampler.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [NUM_CH-1:0] frame_t;

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable settle down-counter; tick is registered and always equals (cnt == 0).
module scan_settle_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    // tick is computed from the value cnt takes at this edge, so it stays in step with cnt
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            tick <= (load_val == '0);
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            tick <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/mux_scan_sampler.sv
// Round-robin scanner for a 4:1 mux: drives selects, samples y after a settle
// delay, and hands completed 4-bit frames to a consumer via valid/ready.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       y_in,
    output logic       s1,
    output logic       s0,
    output logic [3:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYC - 1);
    localparam sel_t             LAST_SEL = SEL_W'(NUM_CH - 1);

    state_t state;
    sel_t   sel;
    frame_t shadow;
    logic   tick;

    logic   timer_load_c;
    logic   timer_clr_c;
    logic   frame_done_c;
    logic   commit_ok_c;
    frame_t commit_word_c;

    // Timer restarts on scan start and on every sample; leaving SETTLE parks it at zero.
    always_comb begin
        timer_load_c  = 1'b0;
        timer_clr_c   = 1'b0;
        frame_done_c  = 1'b0;
        commit_ok_c   = !frame_valid || frame_ready;
        commit_word_c = {y_in, shadow[NUM_CH-2:0]};
        case (state)
            IDLE: begin
                timer_load_c = en;
            end
            SETTLE: begin
                frame_done_c = tick && (sel == LAST_SEL);
                timer_clr_c  = !en;
                timer_load_c = en && tick;
            end
            default: begin
                timer_clr_c = 1'b1;
            end
        endcase
    end

    scan_settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr_c),
        .load     (timer_load_c),
        .load_val (RELOAD),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            // A commit on the accept edge wins over the clear above.
            if (frame_done_c) begin
                if (commit_ok_c) begin
                    frame_data  <= commit_word_c;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= SETTLE;
                        sel   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!en) begin
                        state  <= IDLE;
                        sel    <= '0;
                        shadow <= '0;
                        busy   <= 1'b0;
                    end else if (tick) begin
                        shadow[sel] <= y_in;
                        sel         <= sel + SEL_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign {s1, s0} = sel;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler with a frame scoreboard (SETTLE_CYC=2 and =1 instances).
module tb_mux_scan_sampler;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b1;
    logic       rdy  = 1'b1;
    logic       ymux = 1'b0;
    logic       ytog = 1'b0;
    logic [3:0] ch   = 4'b0000;
    logic       y_in, s1, s0, fv, ovr, busy;
    logic [3:0] fd;
    logic [1:0] sel;

    logic       en1  = 1'b0;
    logic       rdy1 = 1'b1;
    logic [3:0] ch1  = 4'b0000;
    logic       y1, s1_1, s0_1, fv1, ovr1, busy1;
    logic [3:0] fd1;
    logic [1:0] sel1;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int ovr1_cnt = 0;
    int frames   = 0;
    int frames1  = 0;

    logic [3:0] q[$];
    logic [3:0] q1[$];

    always #5 clk = ~clk;

    // Mux models: y reflects the channel currently selected by the DUT.
    assign sel  = {s1, s0};
    assign sel1 = {s1_1, s0_1};
    assign y_in = ymux ? ch[sel] : ytog;
    assign y1   = ch1[sel1];

    mux_scan_sampler #(.SETTLE_CYC(2), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .y_in        (y_in),
        .s1          (s1),
        .s0          (s0),
        .frame_data  (fd),
        .frame_valid (fv),
        .frame_ready (rdy),
        .overrun     (ovr),
        .busy        (busy)
    );

    mux_scan_sampler #(.SETTLE_CYC(1), .CNT_W(4)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .en          (en1),
        .y_in        (y1),
        .s1          (s1_1),
        .s0          (s0_1),
        .frame_data  (fd1),
        .frame_valid (fv1),
        .frame_ready (rdy1),
        .overrun     (ovr1),
        .busy        (busy1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboards: a frame is popped when the consumer accepts it.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && fv && rdy) begin
            if (q.size() != 0) e = q.pop_front();
            else e = 4'bxxxx;
            frames++;
            chk("sb_frame", 16'(fd), 16'(e));
        end
        if (ovr === 1'b1) ovr_cnt++;
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && fv1 && rdy1) begin
            if (q1.size() != 0) e = q1.pop_front();
            else e = 4'bxxxx;
            frames1++;
            chk("sb1_frame", 16'(fd1), 16'(e));
        end
        if (ovr1 === 1'b1) ovr1_cnt++;
    end

    initial begin
        // Reset held with en high and y toggling
        step(1);
        chk("reset_outs_0", 16'({s1, s0, fd, fv, ovr, busy}), 16'h0);
        ytog = 1'b1;
        step(1);
        chk("reset_outs_1", 16'({s1, s0, fd, fv, ovr, busy}), 16'h0);
        chk("reset_outs1", 16'({s1_1, s0_1, fd1, fv1, ovr1, busy1}), 16'h0);

        // Basic frame a=1 b=0 c=1 d=1, en dropped on the channel-3 sample edge
        rst  = 1'b0;
        ymux = 1'b1;
        ch   = 4'b1101;
        q.push_back(4'b1101);
        step(1);
        chk("start_busy", 16'(busy), 16'h1);
        chk("start_sel", 16'(sel), 16'h0);
        for (int i = 1; i <= 7; i++) begin
            step(1);
            chk($sformatf("basic_sel_%0d", i), 16'(sel), 16'(i / 2));
        end
        en = 1'b0;
        step(1);
        chk("basic_valid", 16'(fv), 16'h1);
        chk("basic_data", 16'(fd), 16'hd);
        chk("basic_idle", 16'({busy, sel}), 16'h0);
        step(1);
        chk("basic_cleared", 16'(fv), 16'h0);

        // Back-pressure: second frame overruns and is discarded
        rdy = 1'b0;
        ch  = 4'b0011;
        q.push_back(4'b0011);
        en  = 1'b1;
        step(9);
        chk("bp_valid1", 16'(fv), 16'h1);
        chk("bp_data1", 16'(fd), 16'h3);
        chk("bp_no_ovr1", 16'(ovr), 16'h0);
        ch = 4'b1010;
        step(7);
        chk("bp_no_ovr_early", 16'(ovr), 16'h0);
        en = 1'b0;
        step(1);
        chk("bp_ovr_pulse", 16'(ovr), 16'h1);
        chk("bp_hold_data", 16'({fv, fd}), 16'h13);
        step(1);
        chk("bp_ovr_end", 16'(ovr), 16'h0);
        chk("bp_hold_data2", 16'({fv, fd}), 16'h13);
        rdy = 1'b1;
        step(1);
        chk("bp_released", 16'(fv), 16'h0);

        // Accept and commit on the same edge
        rdy = 1'b0;
        ch  = 4'b0110;
        q.push_back(4'b0110);
        en  = 1'b1;
        step(9);
        chk("sim_valid1", 16'({fv, fd}), 16'h16);
        ch = 4'b1001;
        q.push_back(4'b1001);
        step(7);
        rdy = 1'b1;
        en  = 1'b0;
        step(1);
        chk("sim_valid2", 16'({fv, fd}), 16'h19);
        chk("sim_no_ovr", 16'(ovr), 16'h0);
        step(1);
        chk("sim_cleared", 16'(fv), 16'h0);

        // Abort after channel 1 sampled, then restart with all-zero inputs
        ch = 4'b1111;
        en = 1'b1;
        step(5);
        chk("abort_sel_before", 16'(sel), 16'h2);
        en = 1'b0;
        step(1);
        chk("abort_idle", 16'({busy, sel}), 16'h0);
        chk("abort_no_frame", 16'(fv), 16'h0);
        step(2);
        chk("abort_still_none", 16'(fv), 16'h0);
        ch = 4'b0000;
        q.push_back(4'b0000);
        en = 1'b1;
        step(8);
        en = 1'b0;
        step(1);
        chk("restart_frame", 16'({fv, fd}), 16'h10);
        step(2);

        // SETTLE_CYC=1 continuous run: a frame every 4 cycles
        ch1 = 4'b0101;
        q1.push_back(4'b0101);
        q1.push_back(4'b0101);
        q1.push_back(4'b0101);
        en1 = 1'b1;
        step(1);
        chk("sc1_sel_0", 16'(sel1), 16'h0);
        for (int n = 1; n <= 11; n++) begin
            step(1);
            chk($sformatf("sc1_sel_%0d", n), 16'(sel1), 16'(n % 4));
            chk($sformatf("sc1_valid_%0d", n), 16'(fv1), 16'((n % 4 == 0) ? 1 : 0));
        end
        en1 = 1'b0;
        step(1);
        chk("sc1_last_frame", 16'({fv1, fd1}), 16'h15);
        chk("sc1_idle", 16'({busy1, sel1}), 16'h0);
        step(3);

        // Totals
        chk("sb_left", 16'(q.size()), 16'h0);
        chk("sb_frames", 16'(frames), 16'h5);
        chk("ovr_count", 16'(ovr_cnt), 16'h1);
        chk("sb1_left", 16'(q1.size()), 16'h0);
        chk("sb1_frames", 16'(frames1), 16'h3);
        chk("ovr1_count", 16'(ovr1_cnt), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Upstream/downstream companion to the team's 4:1 mux.
- Drives the mux select lines s1,s0 round-robin over channels 0..3 and waits a programmable settle time per channel.
- Samples the returning mux output y and packs the four samples into a 4-bit frame.
- Presents each frame to a consumer over a valid/ready handshake with a one-entry holding register and overrun flag.

Parameters:
SETTLE_CYC, 2, cycles from select change to sample of y_in; legal range 1..15
CNT_W, 4, width of settle counter; must hold SETTLE_CYC-1

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  scan enable; sampled every cycle
y_in  input  1  mux output for the currently selected channel
s1  output  1  select MSB to mux, registered
s0  output  1  select LSB to mux, registered
frame_data  output  4  bit k = sample of channel k; stable while frame_valid=1
frame_valid  output  1  frame available
frame_ready  input  1  consumer accepts frame when valid&ready at clock edge
overrun  output  1  one-cycle pulse: completed frame dropped because holding register full
busy  output  1  1 while FSM not in IDLE

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at edge): state=IDLE, {s1,s0}=00, cnt=0, shadow=0, frame_data=0, frame_valid=0, overrun=0, busy=0. rst overrides every other input.
- FSM states: IDLE, SETTLE.
- IDLE: {s1,s0}=00. en=1 at edge -> SETTLE, sel=0, cnt=SETTLE_CYC-1.
- SETTLE, cnt!=0: cnt decrements.
- SETTLE, cnt==0 at edge:
  - shadow[sel]<=y_in.
  - sel<=sel+1, wrapping 3->0.
  - cnt reloads SETTLE_CYC-1.
- Timing: en seen at edge t gives sample of channel k at edge t+(k+1)*SETTLE_CYC. Throughput: one frame per 4*SETTLE_CYC cycles with no idle gap when en stays high.
- Frame complete (sample of sel==3):
  - Commit word = {y_in, shadow[2:0]}.
  - Commit succeeds if frame_valid==0, or frame_valid & frame_ready at the same edge. frame_data<=word, frame_valid<=1; valid is visible in the cycle after the sampling edge.
  - Otherwise frame_valid stays 1 and frame_data is unchanged; the new word is discarded and overrun=1 for exactly one cycle.
  - After a frame: en=1 -> continue SETTLE at sel=0; en=0 -> IDLE.
- en=0 at any edge in SETTLE without frame completion:
  - Partial frame abandoned; shadow cleared.
  - Next state IDLE, sel=0.
  - Holding register unaffected.
- en=0 on the same edge as the channel-3 sample: the frame completes and commits, then IDLE.
- Handshake:
  - frame_valid deasserts at the edge where frame_ready=1, unless a commit occurs on that same edge (then it stays 1 with the new data).
  - frame_ready while frame_valid=0 is ignored.
- busy = (state != IDLE), registered.
- No combinational path from y_in or frame_ready to any output.

Decomposition:
- Shared package mux_scan_pkg:
  - state enum (IDLE, SETTLE)
  - constant NUM_CH=4
  - constant SEL_W=2
- One natural sub-module: scan_settle_timer (loadable down-counter, CNT_W wide, outputs tick when cnt==0). It is instantiated once; the FSM, shadow register and holding register live in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and y_in toggling -> all outputs 0, busy=0; rst released with en=1 -> busy=1 one cycle later, {s1,s0}=00.
- Basic frame, SETTLE_CYC=2, frame_ready tied 1:
  - Stimulus: y_in driven as channels a=1, b=0, c=1, d=1 from a mux model.
  - Select sequence: 00,00,01,01,10,10,11,11.
  - Response: frame_data=4'b1101 with frame_valid high for 1 cycle, 9 cycles after en edge.
- Back-pressure: frame_ready=0 for 2 full frames with inputs 4'b0011 then 4'b1010 -> frame_data holds 4'b0011, overrun pulses once at the second frame commit, 4'b1010 is never presented; frame_ready=1 then clears frame_valid.
- Simultaneous accept and commit: frame_ready=1 on the exact edge the next frame commits -> frame_valid stays 1, frame_data switches to the new word, no overrun.
- Abort mid-frame: en dropped after channel 1 is sampled -> IDLE next cycle, {s1,s0}=00, no frame produced; en re-asserted -> new frame starts at channel 0 with shadow cleared (all-zero y_in gives frame 4'b0000).
- SETTLE_CYC=1 continuous run with en held high for 12 cycles -> select changes every cycle 00,01,10,11,00,... and 3 frames are produced, one every 4 cycles.
